// File: rtl/mem_port_ctrl_pkg.sv
// Shared types for the memory-port sequencer: FSM state encoding and the
// byte-lane enable patterns driven onto mem_byte_enable.
package mem_port_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Lane enables for an access: words use both lanes, bytes pick the lane
  // addressed by the low address bit.
  function automatic logic [1:0] lane_enable(input logic byte_acc, input logic addr0);
    if (!byte_acc) return BE_WORD;
    return addr0 ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/mem_port_ctrl_byte_align.sv
// byte_align: turns raw memory read data into the value the MDR expects.
// Word loads pass through untouched; byte loads pick the addressed lane and
// zero- or sign-extend it to the full datapath width.
module byte_align #(
  parameter int width = 16
) (
  input  logic [width-1:0] rdata,
  input  logic             addr0,
  input  logic             byte_acc,
  input  logic             sext,
  output logic [width-1:0] aligned
);

  logic [7:0] lane;

  generate
    if (width >= 16) begin : g_two_lanes
      assign lane = addr0 ? rdata[15:8] : rdata[7:0];
    end else begin : g_one_lane
      assign lane = rdata[7:0];
    end
  endgenerate

  // Choose between the raw word and the extended byte lane.
  always_comb begin
    aligned = rdata;
    if (byte_acc) begin
      if (sext) aligned = width'($signed(lane));
      else      aligned = width'(lane);
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-request memory sequencer with a valid/ready front end.
// A request is latched in IDLE, the registered strobe is held through ACCESS
// until mem_resp, and DONE emits a one-cycle rsp_valid with aligned load data.
// Optional build macro MEM_TIMEOUT_EN adds a watchdog that abandons an access
// after TIMEOUT_CYCLES cycles and flags it with rsp_err.
module mem_port_ctrl
  import mem_port_types::*;
#(
  parameter int width          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic             req_byte,
  input  logic             req_sext,
  input  logic [width-1:0] req_addr,
  input  logic [width-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [width-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [width-1:0] mem_address,
  output logic [width-1:0] mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_byte_enable,
  input  logic             mem_resp,
  input  logic [width-1:0] mem_rdata
);

  state_t           state_q, state_d;
  logic             write_q, byte_q, sext_q, addr0_q;
  logic             timeout_hit;
  logic [width-1:0] aligned;
  logic [width-1:0] store_data;

  // Byte stores replicate the low byte onto both lanes so either lane enable
  // writes the right value; the cast zero-pads wider datapaths.
  assign store_data = req_byte ? width'({req_wdata[7:0], req_wdata[7:0]}) : req_wdata;

  byte_align #(.width(width)) u_align (
    .rdata    (mem_rdata),
    .addr0    (addr0_q),
    .byte_acc (byte_q),
    .sext     (sext_q),
    .aligned  (aligned)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Watchdog: counts cycles spent in ACCESS, cleared whenever outside it.
  always_ff @(posedge clk) begin
    if (reset || state_q != ACCESS) cnt_q <= '0;
    else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error flag is set only for an abandoned access; a response on the limit cycle wins.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (state_q == ACCESS) err_q <= timeout_hit && !mem_resp;
    else if (state_q == DONE) err_q <= 1'b0;
  end

  assign rsp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: mem_resp only matters while an access is outstanding.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  if (mem_resp || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
  end

  // Request capture and memory strobes: everything facing memory is
  // registered so it is stable for the whole ACCESS state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= BE_WORD;
      write_q         <= 1'b0;
      byte_q          <= 1'b0;
      sext_q          <= 1'b0;
      addr0_q         <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      mem_read        <= !req_write;
      mem_write       <= req_write;
      mem_address     <= {req_addr[width-1:1], 1'b0};
      mem_wdata       <= store_data;
      mem_byte_enable <= lane_enable(req_byte, req_addr[0]);
      write_q         <= req_write;
      byte_q          <= req_byte;
      sext_q          <= req_sext;
      addr0_q         <= req_addr[0];
    end else if (state_q == ACCESS && state_d != ACCESS) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Load data capture on the response cycle; stores leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) rsp_rdata <= '0;
    else if (state_q == ACCESS && mem_resp && !write_q) rsp_rdata <= aligned;
  end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
Memory-port sequencer between the datapath's MAR/MDR select muxes and the external memory. It latches one load/store request from the control unit and drives mem_read/mem_write until mem_resp. It then returns read data, aligned and extended for byte accesses, to the MDR input mux. It replaces ad-hoc control-FSM wait states with a single valid/ready handshake.

Parameters:
width, 16, data/address width in bits (even, >= 8)
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with MEM_TIMEOUT_EN

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  control requests an access
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_byte  in  1  1 = byte access (LDB/STB), 0 = word
req_sext  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  width  byte address
req_wdata  in  width  store data; byte stores use bits [7:0]
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  width  aligned load data; held until next rsp_valid
rsp_err  out  1  valid with rsp_valid; 1 = timed out (MEM_TIMEOUT_EN only)
mem_address  out  width  memory address
mem_wdata  out  width  memory write data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_byte_enable  out  2  lane enables, [1] = high byte
mem_resp  in  1  memory completion; 1 cycle or longer

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0; rsp_err 0; mem_read 0; mem_write 0; mem_address 0; mem_wdata 0; mem_byte_enable 2'b11.
- States: IDLE, ACCESS, DONE.
- IDLE: req_ready = 1.
  - On req_valid, latch addr, wdata, write, byte and sext. Go to ACCESS.
  - mem_read/mem_write rise on the next cycle. They are registered, never combinational from req_*.
- ACCESS: req_ready = 0.
  - Exactly one of mem_read/mem_write is high. mem_address, mem_wdata and mem_byte_enable are stable for the whole state.
  - When mem_resp = 1 sampled: drop the strobe next cycle, capture the read data, go to DONE.
- DONE: rsp_valid = 1 for exactly one cycle, req_ready = 0. Go to IDLE.
  - Minimum latency is 3 cycles from request acceptance to rsp_valid, when mem_resp is 1 in the first ACCESS cycle.
- Word access:
  - mem_address = {addr[width-1:1], 1'b0}, enable 2'b11.
  - An odd address is silently aligned down.
  - Load data is passed unchanged.
- Byte store:
  - mem_wdata = {wdata[7:0], wdata[7:0]}, zero-padded above bit 15 if width > 16.
  - Enable = addr[0] ? 2'b10 : 2'b01.
- Byte load:
  - Select mem_rdata[15:8] if addr[0], else [7:0].
  - Zero- or sign-extend to width per sext.
- mem_resp sampled outside ACCESS is ignored.
- A request during ACCESS or DONE is not accepted because req_ready = 0. The requester holds req_valid and the request is taken in IDLE.
- rsp_rdata updates only for loads. A store leaves it unchanged.
- Reset asserted mid-ACCESS:
  - Strobes go to 0 the next cycle and state returns to IDLE.
  - No rsp_valid is issued.
  - A later stale mem_resp in IDLE is ignored.
- mem_rdata is an additional input: mem_rdata  in  width. It is sampled only on the mem_resp cycle.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACCESS. It clears on entry and saturates at TIMEOUT_CYCLES.
  - If it reaches TIMEOUT_CYCLES without mem_resp: drop the strobe, go to DONE, and assert rsp_err = 1 with rsp_valid. rsp_rdata is unchanged.
  - If mem_resp arrives in the same cycle the limit is reached, the response wins and rsp_err = 0.
- Undefined: no counter. ACCESS waits indefinitely and rsp_err is tied to 0.

Decomposition:
- Package mem_port_types: state enum (IDLE, ACCESS, DONE); byte-enable constants BE_WORD = 2'b11, BE_LO = 2'b01, BE_HI = 2'b10.
- Sub-module byte_align, combinational: takes rdata, addr0, byte and sext and produces aligned load data. It is reused by any future load path.

Test Plan:
- Word load at 0x1235 with mem_resp after 2 wait cycles, mem_rdata = 0xBEEF → mem_address = 0x1234, enable 11, mem_read high for 3 cycles, rsp_valid once, rsp_rdata = 0xBEEF.
- Byte store at 0x0101, wdata = 0x00A5 → mem_wdata = 0xA5A5, enable 10, mem_write high until mem_resp, rsp_rdata unchanged.
- Byte load at 0x0101, mem_rdata = 0x80FF → sext = 1 gives 0xFF80; sext = 0 gives 0x0080.
- req_valid held continuously with two queued loads, mem_resp immediate → accepts spaced 3 cycles apart, two rsp_valid pulses, no strobe overlap.
- reset asserted during ACCESS, followed by a spurious mem_resp → strobes 0 next cycle, req_ready = 1, no rsp_valid.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mem_resp never asserted → strobe dropped after 4 cycles, rsp_valid with rsp_err = 1.
